// File: rtl/frame_buff_pkg.sv
// Frame threshold buffer shared types.
// FSM encoding and default threshold coefficients.
package frame_buff_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int THR_MUL_DEF    = 3;
  localparam int THR_SHIFT_DEF  = 3;
  localparam int THR_OFFSET_DEF = 10;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with exact registered occupancy.
// Full is judged before a same-cycle pop frees a slot.
module sync_fifo
  import frame_buff_pkg::*;
#(
  parameter int DATA_W = 9,
  parameter int DEPTH = 1024,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty,
  output logic [LW-1:0]     level
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rptr];

  // storage array, written only on an accepted push
  always_ff @(posedge i_clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  // pointers wrap naturally; level tracks push/pop balance
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop) rptr <= rptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/frame_threshold_buff.sv
// Frame buffer that holds a burst until a length-derived
// threshold is met (or the burst ends), then drains it.
module frame_threshold_buff
  import frame_buff_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH = 1024,
  parameter int LEN_W = 16,
  parameter int THR_MUL = THR_MUL_DEF,
  parameter int THR_SHIFT = THR_SHIFT_DEF,
  parameter int THR_OFFSET = THR_OFFSET_DEF,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_write_valid,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_sof,
  input  logic [LEN_W-1:0]  i_data_length,
  input  logic              i_rd_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_sof,
  output logic [LW-1:0]     o_level,
  output logic              o_full,
  output logic              o_overflow
);

  localparam int TW = LEN_W + $clog2(THR_MUL) + 1;

  state_t           state_q;
  state_t           state_d;
  logic             wv_q;
  logic             burst_start;
  logic             wr_fall;
  logic [LEN_W-1:0] len_q;
  logic [TW-1:0]    prod;
  logic [TW-1:0]    thr_raw;
  logic [LW-1:0]    thr;
  logic             fifo_empty;
  logic             pop;
  logic [DATA_W:0]  rd_word;

  assign burst_start = i_write_valid & ~wv_q;
  assign wr_fall     = ~i_write_valid & wv_q;

  assign prod    = TW'(len_q) * TW'(THR_MUL);
  assign thr_raw = (prod >> THR_SHIFT) + TW'(THR_OFFSET);
  assign thr     = (thr_raw > TW'(DEPTH)) ? LW'(DEPTH)
                                          : LW'(thr_raw);

  assign pop = (state_q == DRAIN) & ~fifo_empty
             & (~o_valid | i_rd_ready);

  sync_fifo #(
    .DATA_W(DATA_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .push   (i_write_valid),
    .pop    (pop),
    .wdata  ({i_sof, i_data}),
    .rdata  (rd_word),
    .full   (o_full),
    .empty  (fifo_empty),
    .level  (o_level)
  );

  // write-strobe history and frame length captured at burst start
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wv_q  <= 1'b0;
      len_q <= '0;
    end else begin
      wv_q <= i_write_valid;
      if (burst_start) len_q <= i_data_length;
    end
  end

  // state register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // next state: fill to threshold or burst end, drain to empty
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (burst_start)      state_d = FILL;
        else if (!fifo_empty) state_d = DRAIN;
      end
      FILL: begin
        if (o_level >= thr || wr_fall) state_d = DRAIN;
      end
      DRAIN: begin
        if (fifo_empty && !pop) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // output word register: load on pop, release after handshake
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_sof   <= 1'b0;
    end else if (pop) begin
      o_valid <= 1'b1;
      o_sof   <= rd_word[DATA_W];
      o_data  <= rd_word[DATA_W-1:0];
    end else if (i_rd_ready) begin
      o_valid <= 1'b0;
    end
  end

  // sticky record of any write dropped while full
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)                        o_overflow <= 1'b0;
    else if (i_write_valid && o_full)    o_overflow <= 1'b1;
  end

endmodule

// File: tb/tb_frame_threshold_buff.sv
// Bench for frame_threshold_buff: two instances (DEPTH 1024 and 16)
// share stimulus; a queue model checks order, level, full, overflow.
module tb_frame_threshold_buff;
  import frame_buff_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        wv;
  logic        sof;
  logic        rdy;
  logic [7:0]  din;
  logic [15:0] dlen;

  logic        ov0, ov1, os0, os1, fu0, fu1, of0, of1;
  logic [7:0]  od0, od1;
  logic [10:0] lv0;
  logic [4:0]  lv1;

  frame_threshold_buff dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_write_valid(wv),
    .i_data(din), .i_sof(sof), .i_data_length(dlen),
    .i_rd_ready(rdy), .o_valid(ov0), .o_data(od0),
    .o_sof(os0), .o_level(lv0), .o_full(fu0),
    .o_overflow(of0)
  );

  frame_threshold_buff #(.DEPTH(16)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_write_valid(wv),
    .i_data(din), .i_sof(sof), .i_data_length(dlen),
    .i_rd_ready(rdy), .o_valid(ov1), .o_data(od1),
    .o_sof(os1), .o_level(lv1), .o_full(fu1),
    .o_overflow(of1)
  );

  int n_chk = 0;
  int n_fail = 0;

  int         dep [2] = '{1024, 16};
  logic [8:0] sb [2][4096];
  int         hd [2], tl [2], sofn [2];
  bit         ovf [2], pv [2];
  logic [8:0] pw [2];
  bit         prev_rdy, rst_done, live;
  int         cyc;
  int         tgt, l_cyc, fv_cyc, dr_cyc, maxl, maxl1;
  bit         full1;

  task automatic check(input bit ok, input string nm,
                       input int act, input int exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  task automatic check_eq(input string nm, input int act,
                          input int exp);
    check(act == exp, nm, act, exp);
  endtask

  function automatic bit g_ov(input int k);
    return (k == 0) ? ov0 : ov1;
  endfunction
  function automatic logic [8:0] g_w(input int k);
    return (k == 0) ? {os0, od0} : {os1, od1};
  endfunction
  function automatic int g_lv(input int k);
    return (k == 0) ? int'(lv0) : int'(lv1);
  endfunction
  function automatic bit g_fu(input int k);
    return (k == 0) ? fu0 : fu1;
  endfunction
  function automatic bit g_of(input int k);
    return (k == 0) ? of0 : of1;
  endfunction

  task automatic step(input int k);
    int c;
    bit nw;
    logic [8:0] w;
    w = g_w(k);
    nw = g_ov(k) && (!pv[k] || prev_rdy);
    if (pv[k] && !prev_rdy) begin
      check_eq($sformatf("hold_valid%0d", k), g_ov(k), 1);
      check_eq($sformatf("hold_word%0d", k), w, pw[k]);
    end
    if (nw) begin
      check(hd[k] < tl[k], $sformatf("extra_word%0d", k),
            hd[k], tl[k]);
      if (hd[k] < tl[k]) begin
        check_eq($sformatf("out_word%0d", k), w, sb[k][hd[k]]);
        hd[k]++;
        if (w[8]) sofn[k]++;
      end
    end
    c = tl[k] - hd[k];
    check_eq($sformatf("level%0d", k), g_lv(k), c);
    check_eq($sformatf("full%0d", k), g_fu(k), int'(c == dep[k]));
    check_eq($sformatf("overflow%0d", k), g_of(k), ovf[k]);
    if (rst_n && wv) begin
      if (c == dep[k]) ovf[k] = 1'b1;
      else begin
        sb[k][tl[k]] = {sof, din};
        tl[k]++;
      end
    end
    pv[k] = g_ov(k);
    pw[k] = w;
  endtask

  initial begin
    cyc = 0;
    rst_done = 1'b0;
    prev_rdy = 1'b0;
    for (int k = 0; k < 2; k++) begin
      hd[k] = 0; tl[k] = 0; sofn[k] = 0;
      ovf[k] = 1'b0; pv[k] = 1'b0; pw[k] = '0;
    end
    forever begin
      @(negedge clk);
      if (live) begin
        cyc++;
        if (rst_done) begin
          for (int k = 0; k < 2; k++) begin
            hd[k] = 0; tl[k] = 0; sofn[k] = 0;
            ovf[k] = 1'b0; pv[k] = 1'b0;
            check_eq($sformatf("rst_valid%0d", k), g_ov(k), 0);
            check_eq($sformatf("rst_level%0d", k), g_lv(k), 0);
            check_eq($sformatf("rst_ovf%0d", k), g_of(k), 0);
          end
        end
        for (int k = 0; k < 2; k++) step(k);
        if (l_cyc < 0 && int'(lv0) >= tgt) l_cyc = cyc;
        if (fv_cyc < 0 && ov0) fv_cyc = cyc;
        if (dr_cyc < 0 && dut0.state_q == DRAIN) dr_cyc = cyc;
        if (int'(lv0) > maxl) maxl = int'(lv0);
        if (int'(lv1) > maxl1) maxl1 = int'(lv1);
        if (fu1) full1 = 1'b1;
        rst_done = !rst_n;
        prev_rdy = rdy;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic newstats(input int t);
    tgt = t; l_cyc = -1; fv_cyc = -1; dr_cyc = -1;
    maxl = 0; maxl1 = 0; full1 = 1'b0;
  endtask

  task automatic rst_pulse();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic burst(input int n, input logic [15:0] len,
                       input int base);
    for (int i = 0; i < n; i++) begin
      wv = 1'b1;
      din = 8'(base + i);
      sof = (i == 0);
      dlen = len;
      tick();
    end
    wv = 1'b0;
    sof = 1'b0;
  endtask

  task automatic settle(input int maxc);
    int n;
    n = 0;
    while (!(dut0.state_q == IDLE && dut1.state_q == IDLE &&
             !ov0 && !ov1 && lv0 == 0 && lv1 == 0) && n < maxc) begin
      tick();
      n++;
    end
    check(n < maxc, "settle_timeout", n, maxc);
    tick();
    tick();
  endtask

  initial begin
    rst_n = 1'b0; wv = 1'b0; sof = 1'b0; rdy = 1'b0;
    din = '0; dlen = '0; live = 1'b0;
    newstats(100000);
    tick();
    live = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // len 64 -> threshold 34
    newstats(34);
    rdy = 1'b1;
    burst(100, 16'd64, 0);
    settle(500);
    check_eq("t1_latency", fv_cyc - l_cyc, 2);
    check_eq("t1_drain_entry", dr_cyc - l_cyc, 1);
    check_eq("t1_peak_level", maxl, 35);
    check_eq("t1_words", hd[0], 100);

    // short frame flushed by falling edge
    rst_pulse();
    newstats(100000);
    rdy = 1'b1;
    burst(20, 16'd1000, 8'h40);
    settle(500);
    check_eq("t2_words", hd[0], 20);
    check_eq("t2_peak_level", maxl, 20);
    check_eq("t2_state", int'(dut0.state_q), int'(IDLE));
    check_eq("t2_words16", hd[1], 18);
    check_eq("t2_ovf16", of1, 1);

    // DEPTH 16 overflow with ready low
    rst_pulse();
    newstats(100000);
    rdy = 1'b0;
    burst(20, 16'd64, 8'h80);
    repeat (5) tick();
    check_eq("t3_full_seen", full1, 1);
    check_eq("t3_peak16", maxl1, 16);
    check_eq("t3_level16", int'(lv1), 16);
    check_eq("t3_ovf16", of1, 1);
    check_eq("t3_ovf1024", of0, 0);
    rdy = 1'b1;
    settle(500);
    check_eq("t3_words16", hd[1], 17);
    check_eq("t3_ovf_sticky", of1, 1);
    check_eq("t3_words1024", hd[0], 20);

    // ready toggling during drain
    rst_pulse();
    newstats(100000);
    rdy = 1'b0;
    burst(10, 16'd8, 8'hC0);
    for (int i = 0; i < 40; i++) begin
      rdy = ~rdy;
      tick();
    end
    rdy = 1'b1;
    settle(500);
    check_eq("t4_words", hd[0], 10);
    check_eq("t4_sof_count", sofn[0], 1);
    check_eq("t4_words16", hd[1], 10);

    // reset mid-drain
    rst_pulse();
    newstats(13);
    rdy = 1'b1;
    burst(30, 16'd8, 8'h10);
    repeat (3) tick();
    check_eq("t5_pre_state", int'(dut0.state_q), int'(DRAIN));
    check(lv0 != 0, "t5_pre_level", int'(lv0), 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check_eq("t5_valid", ov0, 0);
    check_eq("t5_level", int'(lv0), 0);
    check_eq("t5_state", int'(dut0.state_q), int'(IDLE));
    repeat (10) tick();
    check_eq("t5_no_words", hd[0], 0);
    check_eq("t5_still_idle", ov0, 0);

    // saturated threshold
    rst_pulse();
    newstats(1024);
    rdy = 1'b1;
    burst(1030, 16'hFFFF, 0);
    settle(3000);
    check_eq("t6_peak_level", maxl, 1024);
    check_eq("t6_drain_entry", dr_cyc - l_cyc, 1);
    check_eq("t6_latency", fv_cyc - l_cyc, 2);
    check_eq("t6_words", hd[0], 1028);
    check_eq("t6_ovf", of0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
